spi_target: RTL and testbench

- SPI target (slave) for the far end of the SoC's SPI master link. Also serves as the bench model of the external device.
- Receives sclk/mosi/ssn, drives miso. Exchanges 8-bit frames, mode 0 (CPOL=0, CPHA=0), MSB first.
- All SPI inputs are oversampled in the local clk domain, so sclk must be slow relative to clk.
- Parallel side has a one-byte TX buffer and an RX holding register with valid/ack and an overrun flag.

---
 rtl/spi_target.sv | 182 ++++++++++++++++++
 tb/tb_spi_target.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI mode-0 target with 8-bit frames, MSB first; SPI inputs are oversampled in the clk domain.
// Edges are seen SYNC_STAGES+1 clk late; the single TX buffer ignores loads while full, and RX overwrites with an overrun flag.
module spi_target #(
  parameter logic [7:0] DEFAULT_TX  = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ssn,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_empty,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ssn_sync_q, ssn_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ssn_prev_q, ssn_prev_d;
  logic [7:0]             txsr_q, txsr_d;
  logic [7:0]             rxsr_q, rxsr_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             txbuf_q, txbuf_d;
  logic                   tx_empty_q, tx_empty_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic                   busy_q, busy_d;

  logic       sclk_s, mosi_s, ssn_s;
  logic       sclk_rise, sclk_fall, ssn_fall, ssn_rise;
  logic       reload;
  logic [7:0] next_tx;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ssn_s     = ssn_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ssn_fall  = ~ssn_s & ssn_prev_q;
  assign ssn_rise  = ssn_s & ~ssn_prev_q;
  assign next_tx   = tx_empty_q ? DEFAULT_TX : txbuf_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ssn_sync_d  = {ssn_sync_q[SYNC_STAGES-2:0], ssn};
    sclk_prev_d = sclk_s;
    ssn_prev_d  = ssn_s;
    state_d     = state_q;
    txsr_d      = txsr_q;
    rxsr_d      = rxsr_q;
    bitcnt_d    = bitcnt_q;
    txbuf_d     = txbuf_q;
    tx_empty_d  = tx_empty_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    busy_d      = busy_q;
    reload      = 1'b0;

    if (tx_load && tx_empty_q) begin
      txbuf_d    = tx_data;
      tx_empty_d = 1'b0;
    end
    if (rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ssn_fall) begin
          state_d   = SHIFT;
          reload    = 1'b1;
          bitcnt_d  = 4'd0;
          miso_oe_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (ssn_rise) begin
          state_d   = IDLE;
          bitcnt_d  = 4'd0;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
          busy_d    = 1'b0;
        end else if (sclk_rise) begin
          rxsr_d   = {rxsr_q[6:0], mosi_s};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            rx_data_d  = rxsr_d;
            rx_valid_d = 1'b1;
            // An ack landing on the completion cycle consumes the old byte, so no overrun.
            overrun_d  = overrun_d | (rx_valid_q & ~rx_ack);
          end
        end else if (sclk_fall) begin
          if (bitcnt_q == 4'd8) begin
            reload   = 1'b1;
            bitcnt_d = 4'd0;
          end else if (bitcnt_q != 4'd0) begin
            txsr_d = {txsr_q[6:0], 1'b0};
            miso_d = txsr_q[6];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reload only takes the buffer when it is full, so it never collides with an accepted tx_load.
    if (reload) begin
      txsr_d = next_tx;
      miso_d = next_tx[7];
      if (!tx_empty_q) tx_empty_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ssn_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      ssn_prev_q  <= 1'b0;
      txsr_q      <= 8'h00;
      rxsr_q      <= 8'h00;
      bitcnt_q    <= 4'd0;
      txbuf_q     <= 8'h00;
      tx_empty_q  <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ssn_sync_q  <= ssn_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ssn_prev_q  <= ssn_prev_d;
      txsr_q      <= txsr_d;
      rxsr_q      <= rxsr_d;
      bitcnt_q    <= bitcnt_d;
      txbuf_q     <= txbuf_d;
      tx_empty_q  <= tx_empty_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      busy_q      <= busy_d;
    end
  end

  assign miso     = miso_q;
  assign miso_oe  = miso_oe_q;
  assign tx_empty = tx_empty_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a task-driven SPI master plus an RX scoreboard monitor.
module tb_spi_target;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n, sclk, mosi, ssn, miso, miso_oe;
  logic [7:0] tx_data, rx_data;
  logic       tx_load, tx_empty, rx_valid, rx_ack, overrun, busy;

  spi_target #(.DEFAULT_TX(8'h00), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ssn(ssn),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_empty(tx_empty), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ack(rx_ack), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       ovr;
  } rx_exp_t;

  rx_exp_t    exp_q[$];
  rx_exp_t    exp_item;
  int         checks = 0;
  int         errors = 0;
  logic       prev_v;
  logic [7:0] prev_d;
  logic [7:0] mi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // An RX event is rx_valid rising, or new data arriving while rx_valid is still held.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v <= 1'b0;
      prev_d <= 8'h00;
    end else begin
      if (rx_valid && (!prev_v || rx_data != prev_d)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %0h expected none", rx_data);
        end else begin
          exp_item = exp_q.pop_front();
          chk("rx_data", {24'h0, rx_data}, {24'h0, exp_item.data});
          chk("rx_overrun", {31'h0, overrun}, {31'h0, exp_item.ovr});
        end
      end
      prev_v <= rx_valid;
      prev_d <= rx_data;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_miso"}, {31'h0, miso}, 32'd0);
    chk({tag, "_miso_oe"}, {31'h0, miso_oe}, 32'd0);
    chk({tag, "_tx_empty"}, {31'h0, tx_empty}, 32'd1);
    chk({tag, "_rx_data"}, {24'h0, rx_data}, 32'd0);
    chk({tag, "_rx_valid"}, {31'h0, rx_valid}, 32'd0);
    chk({tag, "_overrun"}, {31'h0, overrun}, 32'd0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'd0);
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
    chk("ack_clears_valid", {31'h0, rx_valid}, 32'd0);
    chk("ack_clears_overrun", {31'h0, overrun}, 32'd0);
  endtask

  task automatic sel();
    ssn = 1'b0;
    repeat (4) @(negedge clk);
    chk("sel_busy", {31'h0, busy}, 32'd1);
    chk("sel_miso_oe", {31'h0, miso_oe}, 32'd1);
  endtask

  task automatic desel();
    repeat (4) @(negedge clk);
    ssn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("desel_miso_oe", {31'h0, miso_oe}, 32'd0);
    chk("desel_busy", {31'h0, busy}, 32'd0);
    chk("desel_miso", {31'h0, miso}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // One sclk period, 4 clk low then 4 clk high; optional rx_ack on the completion cycle.
  task automatic xbit(input logic b, input bit ack_here, output logic m);
    mosi = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    m = miso;
    if (ack_here) begin
      repeat (SYNC) @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      repeat (4 - SYNC - 1) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    sclk = 1'b0;
  endtask

  task automatic xbyte(input logic [7:0] mo, input bit ack_last, output logic [7:0] got);
    logic m;
    got = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      xbit(mo[i], ack_last && (i == 0), m);
      got = {got[6:0], m};
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic m;
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ssn = 1'b1;
    tx_data = 8'h00; tx_load = 1'b0; rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // T1: preloaded A5 out, 3C in
    load(8'hA5);
    chk("t1_tx_full", {31'h0, tx_empty}, 32'd0);
    sel();
    chk("t1_tx_empty_at_sel", {31'h0, tx_empty}, 32'd1);
    exp_q.push_back('{data: 8'h3C, ovr: 1'b0});
    xbyte(8'h3C, 1'b0, mi);
    chk("t1_miso", {24'h0, mi}, 32'hA5);
    desel();
    ack();

    // T2: empty buffer sends DEFAULT_TX
    sel();
    exp_q.push_back('{data: 8'hFF, ovr: 1'b0});
    xbyte(8'hFF, 1'b0, mi);
    chk("t2_miso", {24'h0, mi}, 32'h00);
    desel();
    ack();

    // T3: back-to-back frames, overrun on the second byte
    load(8'h11);
    sel();
    load(8'h22);
    chk("t3_tx_full", {31'h0, tx_empty}, 32'd0);
    exp_q.push_back('{data: 8'h01, ovr: 1'b0});
    exp_q.push_back('{data: 8'h02, ovr: 1'b1});
    xbyte(8'h01, 1'b0, mi);
    chk("t3_miso0", {24'h0, mi}, 32'h11);
    xbyte(8'h02, 1'b0, mi);
    chk("t3_miso1", {24'h0, mi}, 32'h22);
    desel();
    chk("t3_overrun", {31'h0, overrun}, 32'd1);
    chk("t3_rx_data", {24'h0, rx_data}, 32'h02);
    ack();

    // T4: abort after 5 bits, then a full 5A frame
    sel();
    for (int i = 7; i >= 3; i--) xbit(i[0], 1'b0, m);
    desel();
    repeat (4) @(negedge clk);
    chk("t4_no_valid", {31'h0, rx_valid}, 32'd0);
    chk("t4_rx_data_kept", {24'h0, rx_data}, 32'h02);
    sel();
    exp_q.push_back('{data: 8'h5A, ovr: 1'b0});
    xbyte(8'h5A, 1'b0, mi);
    chk("t4_miso", {24'h0, mi}, 32'h00);
    desel();
    ack();

    // T5: rx_ack coincides with second byte completion
    sel();
    exp_q.push_back('{data: 8'h66, ovr: 1'b0});
    exp_q.push_back('{data: 8'h99, ovr: 1'b0});
    xbyte(8'h66, 1'b0, mi);
    xbyte(8'h99, 1'b1, mi);
    desel();
    chk("t5_rx_valid", {31'h0, rx_valid}, 32'd1);
    chk("t5_overrun", {31'h0, overrun}, 32'd0);
    chk("t5_rx_data", {24'h0, rx_data}, 32'h99);

    // T6: asynchronous reset mid-frame after 3 bits
    sel();
    load(8'h44);
    for (int i = 0; i < 3; i++) xbit(1'b1, 1'b0, m);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_idle_after_release", {31'h0, busy}, 32'd0);
    ssn = 1'b1;
    repeat (6) @(negedge clk);
    sel();
    exp_q.push_back('{data: 8'hC3, ovr: 1'b0});
    xbyte(8'hC3, 1'b0, mi);
    chk("t6_miso", {24'h0, mi}, 32'h00);
    desel();

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
